// File: rtl/inst_fetch_port_pkg.sv
// Shared types and constants for the instruction fetch port.
package inst_fetch_port_pkg;

  // Level of rst that holds the block in reset.
  localparam logic RSTN_ENABLE = 1'b0;

  // Fetch FSM: IDLE serves hits and launches misses, BUSY waits for the memory ack.
  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_BUSY = 1'b1
  } fetch_state_t;

  // Width of a counter that must hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/inst_fetch_port_if.sv
// Bundles for the fetch port: the PC-side fetch handshake and the
// wait-stated instruction memory bus.

// PC register / IF-ID side. master = pipeline, slave = fetch port.
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ce_i;
  logic [ADDR_W-1:0] pc_i;
  logic              flush_i;
  logic              inval_i;
  logic [DATA_W-1:0] inst_o;
  logic              inst_valid_o;
  logic              stallreq_o;

  modport master (
    output ce_i, pc_i, flush_i, inval_i,
    input  inst_o, inst_valid_o, stallreq_o
  );

  modport slave (
    input  ce_i, pc_i, flush_i, inval_i,
    output inst_o, inst_valid_o, stallreq_o
  );
endinterface

// Instruction memory bus. master = fetch port, slave = memory.
interface inst_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/inst_fetch_port.sv
// Instruction fetch port: holds one fetched word, answers hits in the same
// cycle, and fetches misses over a req/ack memory bus while stalling the pipe.
module inst_fetch_port
  import inst_fetch_port_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.slave  fetch,
  inst_mem_if.master   mem,
  output logic         bus_err_o
);

  localparam int                CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t      state_q, state_d;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              line_valid_q;
  logic [ADDR_W-1:0] line_addr_q;
  logic [DATA_W-1:0] line_data_q;
  logic              drop_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              err_q;

  logic [ADDR_W-1:0] pc_word;
  logic              busy;
  logic              hit;
  logic              ack_take;
  logic              start;

  // Byte offset of the pc is irrelevant for a word-wide memory.
  assign pc_word  = fetch.pc_i & ~ADDR_W'(3);
  assign busy     = (state_q == FETCH_BUSY);
  // An invalidate in this cycle already hides the held word.
  assign hit      = fetch.ce_i & line_valid_q & ~fetch.inval_i & (pc_word == line_addr_q);
  // Acks outside an outstanding request are ignored.
  assign ack_take = busy & mem.mem_ack_i;

  assign mem.mem_req_o  = req_q;
  assign mem.mem_addr_o = addr_q;
  assign bus_err_o      = err_q;

  // Next-state decode and the combinational pipeline-facing outputs.
  always_comb begin
    state_d            = state_q;
    start              = 1'b0;
    fetch.inst_o       = '0;
    fetch.inst_valid_o = 1'b0;
    fetch.stallreq_o   = 1'b0;
    if (hit) begin
      fetch.inst_o       = line_data_q;
      fetch.inst_valid_o = 1'b1;
    end
    if (rst != RSTN_ENABLE) begin
      fetch.stallreq_o = fetch.ce_i & ~hit;
    end
    unique case (state_q)
      FETCH_IDLE: begin
        if (fetch.ce_i && !hit && !fetch.inval_i) begin
          start   = 1'b1;
          state_d = FETCH_BUSY;
        end
      end
      FETCH_BUSY: begin
        if (ack_take) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) state_q <= FETCH_IDLE;
    else                    state_q <= state_d;
  end

  // Memory request: launched on a miss, held untouched until the ack.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      req_q  <= 1'b0;
      addr_q <= '0;
    end else if (start) begin
      req_q  <= 1'b1;
      addr_q <= pc_word;
    end else if (ack_take) begin
      req_q  <= 1'b0;
    end
  end

  // Held line: filled on an ack unless a flush or invalidate killed the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      line_valid_q <= 1'b0;
      line_addr_q  <= '0;
      line_data_q  <= '0;
    end else if (fetch.inval_i) begin
      line_valid_q <= 1'b0;
    end else if (ack_take && !drop_q && !fetch.flush_i) begin
      line_valid_q <= 1'b1;
      line_addr_q  <= addr_q;
      line_data_q  <= mem.mem_rdata_i;
    end
  end

  // Drop flag: remembers a flush seen while the request was outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE)          drop_q <= 1'b0;
    else if (start || ack_take)      drop_q <= 1'b0;
    else if (busy && fetch.flush_i)  drop_q <= 1'b1;
  end

  // Ack watchdog: counts unanswered BUSY cycles and latches a sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (start || ack_take) begin
      wait_cnt_q <= '0;
    end else if (busy) begin
      if (wait_cnt_q != CNT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (wait_cnt_q == CNT_LAST) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Bench for inst_fetch_port: directed scenarios with literal expectations,
// then randomized traffic, all checked against a transaction-level model.
module tb_inst_fetch_port;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bus_err;

  int checks   = 0;
  int failures = 0;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) fif ();
  inst_mem_if   #(.ADDR_W(32), .DATA_W(32)) mif ();

  inst_fetch_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fif.slave),
    .mem       (mif.master),
    .bus_err_o (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding fetch (m_pend/m_addr/m_drop), one held word, a count of
  // unanswered request cycles and the sticky error.
  logic        m_pend, m_drop, m_lv, m_err;
  logic [31:0] m_addr, m_la, m_ld;
  int          m_wait;

  initial begin
    logic        hit, ack;
    logic [31:0] pcw;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_pend = 0; m_drop = 0; m_lv = 0; m_err = 0;
        m_addr = 0; m_la = 0; m_ld = 0; m_wait = 0;
        chk("rst_inst",  fif.inst_o, 32'h0);
        chk("rst_valid", 32'(fif.inst_valid_o), 32'h0);
        chk("rst_stall", 32'(fif.stallreq_o), 32'h0);
        chk("rst_req",   32'(mif.mem_req_o), 32'h0);
        chk("rst_addr",  mif.mem_addr_o, 32'h0);
        chk("rst_err",   32'(bus_err), 32'h0);
      end else begin
        pcw = {fif.pc_i[31:2], 2'b00};
        hit = fif.ce_i && m_lv && !fif.inval_i && (pcw == m_la);
        chk("inst",  fif.inst_o, hit ? m_ld : 32'h0);
        chk("valid", 32'(fif.inst_valid_o), 32'(hit));
        chk("stall", 32'(fif.stallreq_o), 32'(fif.ce_i && !hit));
        chk("req",   32'(mif.mem_req_o), 32'(m_pend));
        if (m_pend) chk("addr", mif.mem_addr_o, m_addr);
        chk("err",   32'(bus_err), 32'(m_err));
        ack = mif.mem_ack_i && m_pend;
        if (m_pend) begin
          if (ack) begin
            m_pend = 0;
            if (!m_drop && !fif.flush_i && !fif.inval_i) begin
              m_lv = 1; m_la = m_addr; m_ld = mif.mem_rdata_i;
            end
            m_drop = 0;
          end else begin
            if (fif.flush_i) m_drop = 1;
            m_wait++;
            if (m_wait >= TIMEOUT) m_err = 1;
          end
        end else if (fif.ce_i && !hit && !fif.inval_i) begin
          m_pend = 1; m_addr = pcw; m_drop = 0; m_wait = 0;
        end
        if (fif.inval_i) m_lv = 0;
      end
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic ce, input logic [31:0] pc, input logic fl,
                       input logic inv, input logic ack, input logic [31:0] rd);
    @(posedge clk); #1;
    fif.ce_i = ce; fif.pc_i = pc; fif.flush_i = fl; fif.inval_i = inv;
    mif.mem_ack_i = ack; mif.mem_rdata_i = rd;
  endtask

  initial begin
    fif.ce_i = 1; fif.pc_i = 32'h100; fif.flush_i = 0; fif.inval_i = 0;
    mif.mem_ack_i = 0; mif.mem_rdata_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall_lit", 32'(fif.stallreq_o), 32'h0);
    chk("reset_req_lit",   32'(mif.mem_req_o), 32'h0);
    @(posedge clk); #1;
    rst = 1; fif.ce_i = 0;

    // Reset asserted while a fetch is outstanding.
    drive(1, 32'h100, 0, 0, 0, 0);
    drive(1, 32'h100, 0, 0, 0, 0);
    #1 chk("t1_req_busy", 32'(mif.mem_req_o), 32'h1);
    #1 rst = 0;
    #1;
    chk("t1_req_drop",  32'(mif.mem_req_o), 32'h0);
    chk("t1_stall_off", 32'(fif.stallreq_o), 32'h0);
    @(posedge clk); #1;
    rst = 1; fif.ce_i = 0;

    // Miss with three wait cycles, ack on the fourth request cycle.
    drive(1, 32'h100, 0, 0, 0, 0);
    #1 chk("t2_issue_stall", 32'(fif.stallreq_o), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 32'h100, 0, 0, (i == 4), 32'h3C010001);
      #1;
      chk("t2_req",   32'(mif.mem_req_o), 32'h1);
      chk("t2_stall", 32'(fif.stallreq_o), 32'h1);
    end
    drive(1, 32'h101, 0, 0, 0, 0);
    #1;
    chk("t2_inst",  fif.inst_o, 32'h3C010001);
    chk("t2_valid", 32'(fif.inst_valid_o), 32'h1);
    chk("t2_stall_drop", 32'(fif.stallreq_o), 32'h0);

    // Held pc hits every cycle with no memory traffic.
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h100, 0, 0, 0, $urandom);
      #1;
      chk("t3_valid", 32'(fif.inst_valid_o), 32'h1);
      chk("t3_req",   32'(mif.mem_req_o), 32'h0);
    end

    // Flush while BUSY: the request runs to its ack but nothing is kept.
    drive(1, 32'h200, 0, 0, 0, 0);
    drive(1, 32'h200, 1, 0, 0, 0);
    drive(1, 32'h200, 0, 0, 0, 0);
    drive(1, 32'h200, 0, 0, 1, 32'hDEADBEEF);
    #1 chk("t4_req_held", 32'(mif.mem_req_o), 32'h1);
    drive(1, 32'h100, 0, 0, 0, 0);
    #1 chk("t4_line_kept", fif.inst_o, 32'h3C010001);
    drive(1, 32'h200, 0, 0, 0, 0);
    #1;
    chk("t4_refetch_valid", 32'(fif.inst_valid_o), 32'h0);
    chk("t4_refetch_stall", 32'(fif.stallreq_o), 32'h1);
    drive(1, 32'h200, 0, 0, 1, 32'h12345678);
    drive(1, 32'h200, 0, 0, 0, 0);
    #1 chk("t4_refetch_inst", fif.inst_o, 32'h12345678);

    // Ack timeout: error after 16 unanswered request cycles, ack still lands.
    drive(1, 32'h300, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      drive(1, 32'h300, 0, 0, 0, 0);
      #1 chk("t5_err_low", 32'(bus_err), 32'h0);
    end
    drive(1, 32'h300, 0, 0, 1, 32'hCAFE0001);
    #1;
    chk("t5_err_set", 32'(bus_err), 32'h1);
    chk("t5_req_wait", 32'(mif.mem_req_o), 32'h1);
    drive(1, 32'h300, 0, 0, 0, 0);
    #1;
    chk("t5_err_sticky", 32'(bus_err), 32'h1);
    chk("t5_inst", fif.inst_o, 32'hCAFE0001);

    // Disabled fetch, stray ack, then invalidate coincident with ack.
    drive(0, 32'h300, 0, 0, 0, 0);
    #1;
    chk("t6_inst_zero",  fif.inst_o, 32'h0);
    chk("t6_stall_zero", 32'(fif.stallreq_o), 32'h0);
    drive(0, 32'h600, 0, 0, 1, 32'h77);
    #1 chk("t6_no_req", 32'(mif.mem_req_o), 32'h0);
    drive(1, 32'h500, 0, 0, 0, 0);
    drive(1, 32'h500, 0, 1, 1, 32'h55);
    drive(1, 32'h500, 0, 0, 0, 0);
    #1;
    chk("t6_inval_valid", 32'(fif.inst_valid_o), 32'h0);
    chk("t6_inval_stall", 32'(fif.stallreq_o), 32'h1);
    drive(1, 32'h500, 0, 0, 1, 32'h66);
    drive(1, 32'h500, 0, 0, 0, 0);
    #1 chk("t6_refill", fif.inst_o, 32'h66);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 499) != 0);
      fif.ce_i    = ($urandom_range(0, 9) != 0);
      fif.pc_i    = 32'h1000 + ($urandom_range(0, 5) << 2) + $urandom_range(0, 3);
      fif.flush_i = ($urandom_range(0, 19) == 0);
      fif.inval_i = ($urandom_range(0, 19) == 0);
      mif.mem_ack_i   = mif.mem_req_o ? ($urandom_range(0, 2) == 0)
                                      : ($urandom_range(0, 9) == 0);
      mif.mem_rdata_i = $urandom;
    end
    @(posedge clk); #1;
    rst = 1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
